// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one instruction-memory read at a time for
// the current PC and queues each returned word, with its PC, in a 2-entry
// buffer for decode. It tells the next-PC mux when the PC may advance. On a
// branch redirect it discards buffered and in-flight fetches. A misaligned PC
// raises a fault flag that stays set until the next redirect.
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        redirect,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        pc_advance,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [1:0]  r_count;
    logic [31:0] r_req_pc;
    logic        r_fault;

    // Buffer entry 0 is always the head, and entry 1 is the tail when count is 2.
    logic [31:0] r_inst0;
    logic [31:0] r_pc0;
    logic [31:0] r_inst1;
    logic [31:0] r_pc1;

    logic w_issue;
    logic w_grant;
    logic w_push;
    logic w_pop;
    logic w_misaligned;

    // Request qualification and buffer handshakes.
    // A request goes out only when the buffer has room for its response.
    always_comb begin
        w_misaligned = (pc_in[1:0] != 2'b00);
        w_issue      = (r_state == S_REQ) && !w_misaligned && !redirect &&
                       !r_fault && (r_count <= 2'd1);
        w_grant      = w_issue && imem_gnt;
        w_push       = (r_state == S_WAIT) && imem_rvalid && !redirect;
        w_pop        = (r_count != 2'd0) && inst_ready;
    end

    assign imem_req    = w_issue;
    assign imem_addr   = pc_in;
    assign pc_advance  = w_grant;
    assign inst_valid  = (r_count != 2'd0);
    assign inst_out    = r_inst0;
    assign inst_pc     = r_pc0;
    assign fetch_fault = r_fault;

    // Fetch control FSM, captured request PC and the sticky misalignment fault.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_req_pc <= 32'd0;
            r_fault  <= 1'b0;
        end else begin
            if (redirect) begin
                r_fault <= 1'b0;
            end else if ((r_state == S_REQ) && w_misaligned) begin
                r_fault <= 1'b1;
            end

            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_grant) begin
                        r_req_pc <= pc_in;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end else if (redirect) begin
                        // The response for the flushed request is still to come.
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // The flushed response completes the outstanding request,
                    // so leaving here is safe even if another redirect arrives
                    // in the same cycle.
                    if (imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Two-entry instruction buffer. A redirect empties it, and that includes
    // any push that arrives in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_inst0 <= 32'd0;
            r_pc0   <= 32'd0;
            r_inst1 <= 32'd0;
            r_pc1   <= 32'd0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_inst0 <= imem_rdata;
                        r_pc0   <= r_req_pc;
                    end else begin
                        r_inst1 <= imem_rdata;
                        r_pc1   <= r_req_pc;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_inst0 <= r_inst1;
                    r_pc0   <= r_pc1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_inst0 <= imem_rdata;
                        r_pc0   <= r_req_pc;
                    end else begin
                        r_inst0 <= r_inst1;
                        r_pc0   <= r_pc1;
                        r_inst1 <= imem_rdata;
                        r_pc1   <= r_req_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector tables for each scenario,
// plus a hand-written sequence for reset asserted in the middle of a fetch.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        redirect;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        pc_advance;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int n_vec;
    int n_mis;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .redirect    (redirect),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_advance  (pc_advance),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic        e_adv;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_flt;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input logic rd, input logic gnt,
                                input logic rv, input logic [31:0] rdata, input logic rdy,
                                input logic e_req, input logic e_adv, input logic e_val,
                                input logic [31:0] e_inst, input logic [31:0] e_ipc,
                                input logic e_flt);
        vec_t v;
        v.pc = pc; v.rd = rd; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.e_req = e_req; v.e_adv = e_adv; v.e_val = e_val;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_flt = e_flt;
        return v;
    endfunction

    // Drive one cycle of inputs, then compare the outputs 1 time unit later.
    task automatic drive_check(input vec_t v, input string tag, input int idx);
        logic ok;
        pc_in = v.pc; redirect = v.rd; imem_gnt = v.gnt; imem_rvalid = v.rv;
        imem_rdata = v.rdata; inst_ready = v.rdy;
        #1;
        n_vec++;
        ok = (imem_req === v.e_req) && (imem_addr === v.pc) && (pc_advance === v.e_adv) &&
             (inst_valid === v.e_val) && (fetch_fault === v.e_flt) &&
             (!v.e_val || ((inst_out === v.e_inst) && (inst_pc === v.e_ipc)));
        if (!ok) begin
            n_mis++;
            $display("FAIL %s[%0d]: got req=%b addr=%h adv=%b val=%b inst=%h ipc=%h flt=%b, want req=%b addr=%h adv=%b val=%b inst=%h ipc=%h flt=%b",
                     tag, idx, imem_req, imem_addr, pc_advance, inst_valid, inst_out, inst_pc,
                     fetch_fault, v.e_req, v.pc, v.e_adv, v.e_val, v.e_inst, v.e_ipc, v.e_flt);
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        drive_check(v, tag, idx);
        @(negedge clk);
    endtask

    task automatic run_table(input vec_t tbl[$], input string tag);
        foreach (tbl[i]) apply(tbl[i], tag, i);
    endtask

    // Assert reset right away, check every output against its reset value, and release on the next falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        pc_in = 32'd0; redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = 32'd0; inst_ready = 1'b0;
        #1;
        n_vec++;
        if (imem_req !== 1'b0 || pc_advance !== 1'b0 || inst_valid !== 1'b0 ||
            inst_out !== 32'd0 || inst_pc !== 32'd0 || fetch_fault !== 1'b0) begin
            n_mis++;
            $display("FAIL %s: got req=%b adv=%b val=%b inst=%h ipc=%h flt=%b, want all zero",
                     tag, imem_req, pc_advance, inst_valid, inst_out, inst_pc, fetch_fault);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t[$];
        n_vec = 0;
        n_mis = 0;

        // Zero-wait memory, decode always ready.
        do_reset("reset_zero_wait");
        t = {};
        //          pc        rd gnt rv rdata          rdy req adv val inst           ipc       flt
        t.push_back(mk(32'h0, 0, 1, 0, 32'h0,          1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h0, 0, 1, 0, 32'h0,          1,  1,  1,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h4, 0, 0, 1, 32'hA000_0000,  1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h4, 0, 1, 0, 32'h0,          1,  1,  1,  1,  32'hA000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 0, 1, 32'hA000_0004,  1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h8, 0, 1, 0, 32'h0,          1,  1,  1,  1,  32'hA000_0004, 32'h4,    0));
        t.push_back(mk(32'hC, 0, 0, 1, 32'hA000_0008,  1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'hC, 0, 0, 0, 32'h0,          1,  1,  0,  1,  32'hA000_0008, 32'h8,    0));
        t.push_back(mk(32'hC, 0, 0, 0, 32'h0,          1,  1,  0,  0,  32'h0,         32'h0,    0));
        run_table(t, "zero_wait");

        // Decode stalls until the buffer is full, then drains in order.
        do_reset("reset_backpressure");
        t = {};
        t.push_back(mk(32'h0, 0, 1, 0, 32'h0,          0,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h0, 0, 1, 0, 32'h0,          0,  1,  1,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h4, 0, 0, 1, 32'hB000_0000,  0,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h4, 0, 1, 0, 32'h0,          0,  1,  1,  1,  32'hB000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 0, 1, 32'hB000_0004,  0,  0,  0,  1,  32'hB000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 1, 0, 32'h0,          0,  0,  0,  1,  32'hB000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 1, 0, 32'h0,          0,  0,  0,  1,  32'hB000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 1, 0, 32'h0,          1,  0,  0,  1,  32'hB000_0000, 32'h0,    0));
        t.push_back(mk(32'h8, 0, 1, 0, 32'h0,          1,  1,  1,  1,  32'hB000_0004, 32'h4,    0));
        t.push_back(mk(32'hC, 0, 0, 1, 32'hB000_0008,  1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'hC, 0, 0, 0, 32'h0,          0,  1,  0,  1,  32'hB000_0008, 32'h8,    0));
        run_table(t, "backpressure");

        // Grant withheld for three cycles while the request is held.
        do_reset("reset_gnt_stall");
        t = {};
        t.push_back(mk(32'h20, 0, 0, 0, 32'h0,         1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h20, 0, 0, 0, 32'h0,         1,  1,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h20, 0, 0, 0, 32'h0,         1,  1,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h20, 0, 0, 0, 32'h0,         1,  1,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h20, 0, 1, 0, 32'h0,         1,  1,  1,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h24, 0, 0, 1, 32'hC000_0020, 1,  0,  0,  0,  32'h0,         32'h0,    0));
        t.push_back(mk(32'h24, 0, 0, 0, 32'h0,         1,  1,  0,  1,  32'hC000_0020, 32'h20,   0));
        run_table(t, "gnt_stall");

        // Redirect while waiting: the late response is dropped and the target fetched.
        do_reset("reset_redirect");
        t = {};
        t.push_back(mk(32'h0,   0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h0,   0, 1, 0, 32'h0,          0, 1, 1, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h4,   1, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h100, 0, 1, 0, 32'h0,          0, 0, 0, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h100, 0, 1, 1, 32'hDEAD_BEEF,  0, 0, 0, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h100, 0, 1, 0, 32'h0,          0, 1, 1, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h104, 0, 0, 1, 32'hD000_0100,  1, 0, 0, 0, 32'h0,          32'h0,   0));
        t.push_back(mk(32'h104, 0, 0, 0, 32'h0,          1, 1, 0, 1, 32'hD000_0100,  32'h100, 0));
        run_table(t, "redirect");

        // Misaligned PC faults, and a redirect clears the fault.
        do_reset("reset_misalign");
        t = {};
        t.push_back(mk(32'h6,  0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        t.push_back(mk(32'h6,  0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        t.push_back(mk(32'h6,  0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        t.push_back(mk(32'h6,  1, 1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        t.push_back(mk(32'h40, 0, 1, 0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0, 0));
        run_table(t, "misalign");

        // Reset asserted while waiting with one entry buffered, then a late response.
        do_reset("reset_midfetch_pre");
        apply(mk(32'h0, 0, 1, 0, 32'h0,         0, 0, 0, 0, 32'h0,         32'h0, 0), "midfetch", 0);
        apply(mk(32'h0, 0, 1, 0, 32'h0,         0, 1, 1, 0, 32'h0,         32'h0, 0), "midfetch", 1);
        apply(mk(32'h4, 0, 0, 1, 32'hE000_0000, 0, 0, 0, 0, 32'h0,         32'h0, 0), "midfetch", 2);
        apply(mk(32'h4, 0, 1, 0, 32'h0,         0, 1, 1, 1, 32'hE000_0000, 32'h0, 0), "midfetch", 3);
        drive_check(mk(32'h8, 0, 0, 0, 32'h0,   0, 0, 0, 1, 32'hE000_0000, 32'h0, 0), "midfetch", 4);
        #1;
        do_reset("reset_midfetch");
        apply(mk(32'h0, 0, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h0, 32'h0, 0), "late_rvalid", 0);
        apply(mk(32'h0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'h0, 32'h0, 0), "late_rvalid", 1);
        apply(mk(32'h0, 0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0, 32'h0, 0), "late_rvalid", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
